// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Access FSM states, requester ids, word size and default memory size.
package data_mem_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {CPU, DBG} req_id_t;

  localparam int WORD_BYTES    = 8;
  localparam int DEF_MEM_BYTES = 32;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view; master is the surrounding system.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  logic              cpuReq;
  logic              cpuWrite;
  logic [ADDR_W-1:0] cpuAddress;
  logic [DATA_W-1:0] cpuWriteData;
  logic              cpuAck;
  logic [DATA_W-1:0] cpuReadData;
  logic              cpuErr;

  logic              dbgReq;
  logic              dbgWrite;
  logic [ADDR_W-1:0] dbgAddress;
  logic [DATA_W-1:0] dbgWriteData;
  logic              dbgAck;
  logic [DATA_W-1:0] dbgReadData;
  logic              dbgErr;

  logic [ADDR_W-1:0] memAddress;
  logic [DATA_W-1:0] memWriteData;
  logic              memWrite;
  logic              memRead;
  logic [DATA_W-1:0] memReadData;

  logic              busy;

  modport slave (
    input  cpuReq, cpuWrite, cpuAddress, cpuWriteData,
    output cpuAck, cpuReadData, cpuErr,
    input  dbgReq, dbgWrite, dbgAddress, dbgWriteData,
    output dbgAck, dbgReadData, dbgErr,
    output memAddress, memWriteData, memWrite, memRead,
    input  memReadData,
    output busy
  );

  modport master (
    output cpuReq, cpuWrite, cpuAddress, cpuWriteData,
    input  cpuAck, cpuReadData, cpuErr,
    output dbgReq, dbgWrite, dbgAddress, dbgWriteData,
    input  dbgAck, dbgReadData, dbgErr,
    input  memAddress, memWriteData, memWrite, memRead,
    output memReadData,
    input  busy
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: grant[0]=CPU, grant[1]=DBG, one-hot.
// lastGrant resets to DBG so the CPU wins the first contested grant.
module rr_arbiter2
  import data_mem_pkg::*;
(
  input  logic       clock,
  input  logic       resetN,
  input  logic       i_req_cpu,
  input  logic       i_req_dbg,
  input  logic       i_en,
  output logic [1:0] o_grant
);

  req_id_t r_last_grant;

  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      if (i_req_cpu && i_req_dbg) begin
        o_grant = (r_last_grant == DBG) ? 2'b01 : 2'b10;
      end else begin
        o_grant = {i_req_dbg, i_req_cpu};
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_last_grant <= DBG;
    end else if (o_grant[0]) begin
      r_last_grant <= CPU;
    end else if (o_grant[1]) begin
      r_last_grant <= DBG;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates CPU and debug-loader accesses onto one data memory (IDLE/ACCESS/RESP).
// Define DATA_MEM_ALIGN_CHECK_EN to reject addresses that are not 8-byte aligned.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = DEF_MEM_BYTES
) (
  input logic               clock,
  input logic               resetN,
  data_mem_arbiter_if.slave bus
);

  // Full-width compare against the last legal word start avoids any wrap-around.
  localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(MEM_BYTES - WORD_BYTES);

  logic [1:0]        w_grant;
  logic              w_arb_en;
  logic              w_any_grant;
  logic              w_sel_dbg;
  logic              w_write;
  logic              w_err;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  state_t            r_state;
  req_id_t           r_winner;
  logic              r_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_write;
  logic              r_mem_read;
  logic              r_cpu_ack;
  logic              r_cpu_err;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_dbg_ack;
  logic              r_dbg_err;
  logic [DATA_W-1:0] r_dbg_rdata;
  logic              r_busy;

  assign w_arb_en = (r_state == IDLE);

  rr_arbiter2 u_arb (
    .clock     (clock),
    .resetN    (resetN),
    .i_req_cpu (bus.cpuReq),
    .i_req_dbg (bus.dbgReq),
    .i_en      (w_arb_en),
    .o_grant   (w_grant)
  );

  assign w_any_grant = |w_grant;
  assign w_sel_dbg   = w_grant[1];
  assign w_write     = w_sel_dbg ? bus.dbgWrite     : bus.cpuWrite;
  assign w_addr      = w_sel_dbg ? bus.dbgAddress   : bus.cpuAddress;
  assign w_wdata     = w_sel_dbg ? bus.dbgWriteData : bus.cpuWriteData;

  always_comb begin
    w_err = (w_addr > LAST_WORD_ADDR);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    w_err = w_err | (w_addr[2:0] != 3'd0);
`endif
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state     <= IDLE;
      r_winner    <= CPU;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_cpu_err   <= 1'b0;
      r_cpu_rdata <= '0;
      r_dbg_ack   <= 1'b0;
      r_dbg_err   <= 1'b0;
      r_dbg_rdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_cpu_err <= 1'b0;
      r_dbg_ack <= 1'b0;
      r_dbg_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_grant) begin
            r_winner    <= w_sel_dbg ? DBG : CPU;
            r_err       <= w_err;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
            r_mem_write <= w_write && !w_err;
            r_mem_read  <= !w_write && !w_err;
            r_busy      <= 1'b1;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          r_mem_write <= 1'b0;
          r_mem_read  <= 1'b0;
          // r_mem_read is already low for writes and rejected accesses
          if (r_winner == CPU) begin
            r_cpu_rdata <= r_mem_read ? bus.memReadData : '0;
            r_cpu_ack   <= 1'b1;
            r_cpu_err   <= r_err;
          end else begin
            r_dbg_rdata <= r_mem_read ? bus.memReadData : '0;
            r_dbg_ack   <= 1'b1;
            r_dbg_err   <= r_err;
          end
          r_state <= RESP;
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.memAddress   = r_mem_addr;
  assign bus.memWriteData = r_mem_wdata;
  assign bus.memWrite     = r_mem_write;
  assign bus.memRead      = r_mem_read;
  assign bus.cpuAck       = r_cpu_ack;
  assign bus.cpuErr       = r_cpu_err;
  assign bus.cpuReadData  = r_cpu_rdata;
  assign bus.dbgAck       = r_dbg_ack;
  assign bus.dbgErr       = r_dbg_err;
  assign bus.dbgReadData  = r_dbg_rdata;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a 32-byte little-endian memory model.
// Honours DATA_MEM_ALIGN_CHECK_EN for the misaligned-read expectation.
module tb_data_mem_arbiter;

  logic clk;
  logic rst_n;
  logic mem_init;
  logic [7:0] mem [0:31];

  int n_checks = 0;
  int n_errors = 0;

  data_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  data_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_BYTES(32)) dut (
    .clock  (clk),
    .resetN (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: pattern 0x10+i at init, byte writes at posedge, combinational read
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h10 + 8'(i);
    end else if (bus.memWrite) begin
      for (int i = 0; i < 8; i++)
        mem[(int'(bus.memAddress[4:0]) + i) % 32] <= bus.memWriteData[8*i +: 8];
    end
  end

  always_comb begin
    bus.memReadData = '0;
    for (int i = 0; i < 8; i++)
      bus.memReadData[8*i +: 8] = mem[(int'(bus.memAddress[4:0]) + i) % 32];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one access on a port; captures ACCESS-cycle bus state and the ack response.
  task automatic access(input bit dbg, input bit wr, input logic [63:0] addr,
                        input logic [63:0] wd, output int lat,
                        output logic a_mw, output logic a_mr, output logic [63:0] a_addr,
                        output logic err, output logic [63:0] rd, output logic other_ack);
    bit got;
    got = 1'b0; lat = -1;
    a_mw = 1'bx; a_mr = 1'bx; a_addr = 'x; err = 1'bx; rd = 'x; other_ack = 1'bx;
    if (dbg) begin
      bus.dbgWrite = wr; bus.dbgAddress = addr; bus.dbgWriteData = wd; bus.dbgReq = 1'b1;
    end else begin
      bus.cpuWrite = wr; bus.cpuAddress = addr; bus.cpuWriteData = wd; bus.cpuReq = 1'b1;
    end
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clk);
      if (i == 1) begin
        a_mw = bus.memWrite; a_mr = bus.memRead; a_addr = bus.memAddress;
      end
      if (dbg ? bus.dbgAck : bus.cpuAck) begin
        got = 1'b1; lat = i;
        err = dbg ? bus.dbgErr : bus.cpuErr;
        rd  = dbg ? bus.dbgReadData : bus.cpuReadData;
        other_ack = dbg ? bus.cpuAck : bus.dbgAck;
      end
    end
    bus.cpuReq = 1'b0;
    bus.dbgReq = 1'b0;
    @(negedge clk);
  endtask

  int          lat;
  logic        a_mw, a_mr, err, oth;
  logic [63:0] a_addr, rd;
  logic [11:0] cpu_vec, dbg_vec, busy_vec;

  initial begin
    rst_n = 1'b0; mem_init = 1'b1;
    bus.cpuReq = 1'b0; bus.cpuWrite = 1'b0; bus.cpuAddress = '0; bus.cpuWriteData = '0;
    bus.dbgReq = 1'b0; bus.dbgWrite = 1'b0; bus.dbgAddress = '0; bus.dbgWriteData = '0;
    repeat (3) @(negedge clk);

    chk("rst_cpuAck",   64'(bus.cpuAck), 64'd0);
    chk("rst_dbgAck",   64'(bus.dbgAck), 64'd0);
    chk("rst_busy",     64'(bus.busy), 64'd0);
    chk("rst_memWrite", 64'(bus.memWrite), 64'd0);
    chk("rst_memRead",  64'(bus.memRead), 64'd0);
    chk("rst_memAddr",  bus.memAddress, 64'd0);
    chk("rst_memWdata", bus.memWriteData, 64'd0);
    chk("rst_cpuRd",    bus.cpuReadData, 64'd0);
    chk("rst_dbgRd",    bus.dbgReadData, 64'd0);

    mem_init = 1'b0; rst_n = 1'b1;
    @(negedge clk);

    // Lone CPU write to 8
    access(1'b0, 1'b1, 64'd8, 64'h1122334455667788, lat, a_mw, a_mr, a_addr, err, rd, oth);
    chk("wr8_lat",   64'(lat), 64'd2);
    chk("wr8_mw",    64'(a_mw), 64'd1);
    chk("wr8_mr",    64'(a_mr), 64'd0);
    chk("wr8_addr",  a_addr, 64'd8);
    chk("wr8_err",   64'(err), 64'd0);
    chk("wr8_other", 64'(oth), 64'd0);

    // CPU read back of 8
    access(1'b0, 1'b0, 64'd8, 64'd0, lat, a_mw, a_mr, a_addr, err, rd, oth);
    chk("rd8_lat",  64'(lat), 64'd2);
    chk("rd8_mr",   64'(a_mr), 64'd1);
    chk("rd8_err",  64'(err), 64'd0);
    chk("rd8_data", rd, 64'h1122334455667788);
    chk("rd8_hold", bus.cpuReadData, 64'h1122334455667788);
    chk("rd8_ack1", 64'(bus.cpuAck), 64'd0);

    // Debug read just out of range, then the last legal word
    access(1'b1, 1'b0, 64'd25, 64'd0, lat, a_mw, a_mr, a_addr, err, rd, oth);
    chk("rd25_err",   64'(err), 64'd1);
    chk("rd25_data",  rd, 64'd0);
    chk("rd25_mr",    64'(a_mr), 64'd0);
    chk("rd25_other", 64'(oth), 64'd0);
    access(1'b1, 1'b0, 64'd24, 64'd0, lat, a_mw, a_mr, a_addr, err, rd, oth);
    chk("rd24_err",  64'(err), 64'd0);
    chk("rd24_data", rd, 64'h2F2E2D2C2B2A2928);
    chk("rd24_lat",  64'(lat), 64'd2);

    // Huge address write must not wrap into low memory
    access(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hAAAA_BBBB_CCCC_DDDD,
           lat, a_mw, a_mr, a_addr, err, rd, oth);
    chk("huge_err", 64'(err), 64'd1);
    chk("huge_mw",  64'(a_mw), 64'd0);
    access(1'b0, 1'b0, 64'd0, 64'd0, lat, a_mw, a_mr, a_addr, err, rd, oth);
    chk("huge_mem0", rd, 64'h1716151413121110);

    // Misaligned CPU read at 4 (bytes 8..11 hold the earlier write)
    access(1'b0, 1'b0, 64'd4, 64'd0, lat, a_mw, a_mr, a_addr, err, rd, oth);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    chk("mis4_err",  64'(err), 64'd1);
    chk("mis4_data", rd, 64'd0);
`else
    chk("mis4_err",  64'(err), 64'd0);
    chk("mis4_data", rd, 64'h5566778817161514);
`endif

    // Reset during ACCESS of a CPU write to 0
    bus.cpuWrite = 1'b1; bus.cpuAddress = 64'd0; bus.cpuWriteData = 64'hDEAD_BEEF_CAFE_F00D;
    bus.cpuReq = 1'b1;
    @(negedge clk);
    chk("abort_mw_pre", 64'(bus.memWrite), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_mw",   64'(bus.memWrite), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    bus.cpuWrite = 1'b0;
    bus.dbgWrite = 1'b0; bus.dbgAddress = 64'd0; bus.dbgReq = 1'b1;
    @(negedge clk);
    chk("abort_ack",  64'(bus.cpuAck), 64'd0);
    chk("abort_rd0",  bus.cpuReadData, 64'd0);

    // Both requesting continuously from reset release
    rst_n = 1'b1;
    cpu_vec = '0; dbg_vec = '0; busy_vec = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cpu_vec[i]  = bus.cpuAck;
      dbg_vec[i]  = bus.dbgAck;
      busy_vec[i] = bus.busy;
      if (bus.cpuAck) chk("arb_cpu_rd0", bus.cpuReadData, 64'h1716151413121110);
      if (bus.dbgAck) chk("arb_dbg_rd0", bus.dbgReadData, 64'h1716151413121110);
    end
    bus.cpuReq = 1'b0; bus.dbgReq = 1'b0;
    chk("arb_cpu_acks", 64'(cpu_vec), 64'h082);
    chk("arb_dbg_acks", 64'(dbg_vec), 64'h410);
    chk("arb_busy",     64'(busy_vec), 64'h6DB);
    repeat (3) @(negedge clk);
    chk("end_idle", 64'(bus.busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
